fp_cvt96_to32_pipe: RTL and testbench

FP_CVT96_TO32_PIPE -- requirements
Module: fp_cvt96_to32_pipe

---
 rtl/fp96Pkg.sv | 57 +++++
 rtl/fp_round32.sv | 73 +++++++
 rtl/fp_cvt96_to32_pipe.sv | 150 +++++++++++++++
 tb/tb_fp_cvt96_to32_pipe.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fp96Pkg.sv
// rtl/fp96Pkg.sv - shared FP96/FP32 types, rounding modes, flags and bias constants
package fp96Pkg;

  localparam logic [7:0]  BIAS32    = 8'h7F;
  localparam logic [14:0] BIAS96    = 15'h3FFF;
  localparam logic [16:0] REBIAS    = {2'b00, BIAS96} - {9'd0, BIAS32};
  localparam logic [4:0]  MAX_SHIFT = 5'd26;
  localparam logic [15:0] EXP_MAX   = {7'd0, BIAS32, 1'b1};

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef struct packed {
    logic        sign;
    logic [14:0] exp;
    logic [79:0] sig;
  } fp96_t;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  typedef enum logic [2:0] {
    CLS_NORM = 3'd0,
    CLS_ZERO = 3'd1,
    CLS_TINY = 3'd2,
    CLS_INF  = 3'd3,
    CLS_NAN  = 3'd4
  } cls_e;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
    logic rsvd;
  } flags_t;

  // Encodings 5-7 fall back to round-to-nearest-even.
  function automatic rm_e decode_rm(input logic [2:0] raw);
    case (raw)
      3'd1:    return RM_RTZ;
      3'd2:    return RM_RDN;
      3'd3:    return RM_RUP;
      3'd4:    return RM_RMM;
      default: return RM_RNE;
    endcase
  endfunction

endpackage

// File: rtl/fp_round32.sv
// rtl/fp_round32.sv - combinational FP32 round and pack with IEEE exception flags
module fp_round32
  import fp96Pkg::*;
(
  input  logic        sign,
  input  logic [2:0]  cls,
  input  logic [15:0] exp_f,
  input  logic [22:0] frac,
  input  logic        guard,
  input  logic        sticky,
  input  logic [22:0] nan_sig,
  input  logic [2:0]  rm,
  output logic [31:0] res,
  output logic [4:0]  flags
);

  rm_e         mode;
  cls_e        c;
  logic        gs;
  logic        inc;
  logic        ovf;
  logic        to_inf;
  logic [38:0] sum;
  fp32_t       r;
  flags_t      f;

  always_comb begin
    mode = rm_e'(rm);
    c    = cls_e'(cls);
    gs   = guard | sticky;
    case (mode)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & gs;
      RM_RUP:  inc = !sign & gs;
      RM_RMM:  inc = guard;
      default: inc = guard & (sticky | frac[0]);
    endcase
    // Adding across the exp/frac boundary carries mantissa overflow into the
    // exponent, which also promotes 0x7FFFFF denormals to the minimum normal.
    sum    = {exp_f, frac} + 39'(inc);
    ovf    = sum[38:23] >= EXP_MAX;
    to_inf = (mode == RM_RNE) || (mode == RM_RMM) ||
             (mode == RM_RUP && !sign) || (mode == RM_RDN && sign);

    r      = '0;
    f      = '0;
    r.sign = sign;
    case (c)
      CLS_ZERO: r.exp = 8'h00;
      CLS_INF:  r.exp = 8'hFF;
      CLS_NAN: begin
        r.exp     = 8'hFF;
        r.frac    = {1'b1, nan_sig[21:0]};
        f.invalid = !nan_sig[22];
      end
      default: begin
        f.overflow  = ovf;
        f.inexact   = gs | ovf;
        f.underflow = (exp_f == 16'd0) & gs;
        if (ovf) begin
          r.exp  = to_inf ? 8'hFF : 8'hFE;
          r.frac = to_inf ? 23'd0 : {23{1'b1}};
        end else begin
          r.exp  = sum[30:23];
          r.frac = sum[22:0];
        end
      end
    endcase
    res   = r;
    flags = f;
  end

endmodule

// File: rtl/fp_cvt96_to32_pipe.sv
// rtl/fp_cvt96_to32_pipe.sv - 3-stage elastic FP96 to FP32 converter
module fp_cvt96_to32_pipe
  import fp96Pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [95:0] i,
  input  logic [2:0]  rm,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [31:0] o,
  output logic [4:0]  o_flags
);

  logic        s1_valid_q, s1_valid_d;
  logic        s1_sign_q, s1_sign_d;
  logic [16:0] s1_e32_q, s1_e32_d;
  logic [79:0] s1_sig_q, s1_sig_d;
  logic [2:0]  s1_cls_q, s1_cls_d;
  logic [2:0]  s1_rm_q, s1_rm_d;

  logic        s2_valid_q, s2_valid_d;
  logic        s2_sign_q, s2_sign_d;
  logic [2:0]  s2_cls_q, s2_cls_d;
  logic [15:0] s2_exp_q, s2_exp_d;
  logic [22:0] s2_frac_q, s2_frac_d;
  logic        s2_guard_q, s2_guard_d;
  logic        s2_sticky_q, s2_sticky_d;
  logic [22:0] s2_nan_q, s2_nan_d;
  logic [2:0]  s2_rm_q, s2_rm_d;

  logic        o_valid_q, o_valid_d;
  logic [31:0] o_q, o_d;
  logic [4:0]  o_flags_q, o_flags_d;

  logic        o_adv, s2_adv, s1_adv, accept;
  logic        exp_zero, exp_ones, sig_zero, e_pos;
  logic [16:0] nsh;
  logic [4:0]  sh;
  logic [106:0] wide;
  logic [31:0] rnd_res;
  logic [4:0]  rnd_flags;

  fp_round32 u_round (
    .sign    (s2_sign_q),
    .cls     (s2_cls_q),
    .exp_f   (s2_exp_q),
    .frac    (s2_frac_q),
    .guard   (s2_guard_q),
    .sticky  (s2_sticky_q),
    .nan_sig (s2_nan_q),
    .rm      (s2_rm_q),
    .res     (rnd_res),
    .flags   (rnd_flags)
  );

  always_comb begin
    o_adv   = o_valid_q & o_ready;
    s2_adv  = s2_valid_q & (!o_valid_q | o_adv);
    s1_adv  = s1_valid_q & (!s2_valid_q | s2_adv);
    i_ready = rst_n & (!s1_valid_q | s1_adv);
    accept  = i_valid & i_ready;

    exp_zero = ~|i[94:80];
    exp_ones = &i[94:80];
    sig_zero = ~|i[79:0];

    s1_valid_d = accept | (s1_valid_q & !s1_adv);
    s1_sign_d  = accept ? i[95] : s1_sign_q;
    s1_e32_d   = accept ? ({2'b00, i[94:80]} - REBIAS) : s1_e32_q;
    s1_sig_d   = accept ? i[79:0] : s1_sig_q;
    s1_rm_d    = accept ? decode_rm(rm) : s1_rm_q;
    s1_cls_d   = s1_cls_q;
    if (accept) begin
      if (exp_zero)      s1_cls_d = sig_zero ? CLS_ZERO : CLS_TINY;
      else if (exp_ones) s1_cls_d = sig_zero ? CLS_INF : CLS_NAN;
      else               s1_cls_d = CLS_NORM;
    end

    // Tiny inputs land on the 26-bit cap, which leaves the hidden one as sticky only.
    e_pos = !s1_e32_q[16] && (s1_e32_q != 17'd0);
    nsh   = 17'd1 - s1_e32_q;
    sh    = e_pos ? 5'd0 : ((nsh > 17'd26) ? MAX_SHIFT : nsh[4:0]);
    wide  = {1'b1, s1_sig_q, 26'd0} >> sh;

    s2_valid_d  = s1_adv | (s2_valid_q & !s2_adv);
    s2_sign_d   = s1_adv ? s1_sign_q : s2_sign_q;
    s2_cls_d    = s1_adv ? s1_cls_q : s2_cls_q;
    s2_rm_d     = s1_adv ? s1_rm_q : s2_rm_q;
    s2_nan_d    = s1_adv ? s1_sig_q[79:57] : s2_nan_q;
    // The hidden bit stays at the top only when no denormalising shift happened.
    s2_exp_d    = s1_adv ? (wide[106] ? s1_e32_q[15:0] : 16'd0) : s2_exp_q;
    s2_frac_d   = s1_adv ? wide[105:83] : s2_frac_q;
    s2_guard_d  = s1_adv ? wide[82] : s2_guard_q;
    s2_sticky_d = s1_adv ? |wide[81:0] : s2_sticky_q;

    o_valid_d = s2_adv | (o_valid_q & !o_adv);
    o_d       = s2_adv ? rnd_res : o_q;
    o_flags_d = s2_adv ? rnd_flags : o_flags_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_e32_q    <= '0;
      s1_sig_q    <= '0;
      s1_cls_q    <= '0;
      s1_rm_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_cls_q    <= '0;
      s2_exp_q    <= '0;
      s2_frac_q   <= '0;
      s2_guard_q  <= 1'b0;
      s2_sticky_q <= 1'b0;
      s2_nan_q    <= '0;
      s2_rm_q     <= '0;
      o_valid_q   <= 1'b0;
      o_q         <= '0;
      o_flags_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_e32_q    <= s1_e32_d;
      s1_sig_q    <= s1_sig_d;
      s1_cls_q    <= s1_cls_d;
      s1_rm_q     <= s1_rm_d;
      s2_valid_q  <= s2_valid_d;
      s2_sign_q   <= s2_sign_d;
      s2_cls_q    <= s2_cls_d;
      s2_exp_q    <= s2_exp_d;
      s2_frac_q   <= s2_frac_d;
      s2_guard_q  <= s2_guard_d;
      s2_sticky_q <= s2_sticky_d;
      s2_nan_q    <= s2_nan_d;
      s2_rm_q     <= s2_rm_d;
      o_valid_q   <= o_valid_d;
      o_q         <= o_d;
      o_flags_q   <= o_flags_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o       = o_q;
  assign o_flags = o_flags_q;

endmodule

// File: tb/tb_fp_cvt96_to32_pipe.sv
// tb/tb_fp_cvt96_to32_pipe.sv - directed self-checking bench for the FP96 to FP32 pipe
module tb_fp_cvt96_to32_pipe;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic        i_ready;
  logic [95:0] i;
  logic [2:0]  rm;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] o;
  logic [4:0]  o_flags;

  int checks;
  int errors;

  localparam logic [4:0] F_NX = 5'b00010;
  localparam logic [4:0] F_UF = 5'b00100;
  localparam logic [4:0] F_OF = 5'b01000;
  localparam logic [4:0] F_NV = 5'b10000;
  localparam logic [79:0] ONES = {80{1'b1}};

  fp_cvt96_to32_pipe dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i       (i),
    .rm      (rm),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o       (o),
    .o_flags (o_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] mk(input logic s, input logic [14:0] e, input logic [79:0] m);
    return {s, e, m};
  endfunction

  // Called just after a rising edge with the pipe empty and o_ready high.
  task automatic send_one(input string tag, input logic [95:0] x, input logic [2:0] m,
                          input logic [31:0] eo, input logic [4:0] ef);
    int n;
    i_valid = 1'b1;
    i       = x;
    rm      = m;
    o_ready = 1'b1;
    #1;
    check($sformatf("%s_rdy", tag), 64'(i_ready), 64'd1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    n = 0;
    while (!o_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("%s_lat", tag), 64'(n), 64'd2);
    check($sformatf("%s_o", tag), 64'(o), 64'(eo));
    check($sformatf("%s_fl", tag), 64'(o_flags), 64'(ef));
    @(posedge clk);
    #1;
  endtask

  logic [95:0] sv [6];
  logic [31:0] so [6];
  int          acc_n, out_n, stall_at;
  logic        took_in, took_out;
  logic [36:0] got;

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    o_ready = 1'b0;
    i       = '0;
    rm      = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ovalid", 64'(o_valid), 64'd0);
    check("rst_iready", 64'(i_ready), 64'd0);
    check("rst_o", 64'(o), 64'd0);
    check("rst_flags", 64'(o_flags), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send_one("one",      mk(0, 15'h3FFF, 80'd0),                 3'd0, 32'h3F800000, 5'd0);
    send_one("tie_rne",  mk(0, 15'h3FFF, 80'd3 << 56),           3'd0, 32'h3F800002, F_NX);
    send_one("tie_rtz",  mk(0, 15'h3FFF, 80'd3 << 56),           3'd1, 32'h3F800001, F_NX);
    send_one("tie_rm7",  mk(0, 15'h3FFF, 80'd3 << 56),           3'd7, 32'h3F800002, F_NX);
    send_one("half_rne", mk(0, 15'h3FFF, 80'd1 << 56),           3'd0, 32'h3F800000, F_NX);
    send_one("half_rmm", mk(0, 15'h3FFF, 80'd1 << 56),           3'd4, 32'h3F800001, F_NX);
    send_one("neg_rdn",  mk(1, 15'h3FFF, 80'd1 << 56),           3'd2, 32'hBF800001, F_NX);
    send_one("neg_rup",  mk(1, 15'h3FFF, 80'd1 << 56),           3'd3, 32'hBF800000, F_NX);
    send_one("ovf_rne",  mk(0, 15'h407F, ONES),                  3'd0, 32'h7F800000, F_OF | F_NX);
    send_one("ovf_rtz",  mk(0, 15'h407F, ONES),                  3'd1, 32'h7F7FFFFF, F_OF | F_NX);
    send_one("ovfn_rup", mk(1, 15'h407F, ONES),                  3'd3, 32'hFF7FFFFF, F_OF | F_NX);
    send_one("ovfn_rdn", mk(1, 15'h407F, ONES),                  3'd2, 32'hFF800000, F_OF | F_NX);
    send_one("min_den",  mk(0, 15'h3F6A, 80'd0),                 3'd0, 32'h00000001, 5'd0);
    send_one("den_tie",  mk(0, 15'h3F69, 80'd0),                 3'd0, 32'h00000000, F_UF | F_NX);
    send_one("promote",  mk(0, 15'h3F80, ONES),                  3'd0, 32'h00800000, F_UF | F_NX);
    send_one("tiny_rup", mk(0, 15'h0000, 80'd1),                 3'd3, 32'h00000001, F_UF | F_NX);
    send_one("tiny_rne", mk(0, 15'h0000, 80'd1),                 3'd0, 32'h00000000, F_UF | F_NX);
    send_one("snan",     mk(1, 15'h7FFF, 80'd1 << 60),           3'd0, 32'hFFC00008, F_NV);
    send_one("qnan",     mk(0, 15'h7FFF, 80'd1 << 79),           3'd0, 32'h7FC00000, 5'd0);
    send_one("pinf",     mk(0, 15'h7FFF, 80'd0),                 3'd0, 32'h7F800000, 5'd0);
    send_one("nzero",    mk(1, 15'h0000, 80'd0),                 3'd0, 32'h80000000, 5'd0);

    sv[0] = mk(0, 15'h3FFF, 80'd0);       so[0] = 32'h3F800000;
    sv[1] = mk(0, 15'h4000, 80'd0);       so[1] = 32'h40000000;
    sv[2] = mk(0, 15'h4000, 80'd1 << 79); so[2] = 32'h40400000;
    sv[3] = mk(1, 15'h3FFF, 80'd0);       so[3] = 32'hBF800000;
    sv[4] = mk(0, 15'h3FFE, 80'd0);       so[4] = 32'h3F000000;
    sv[5] = mk(0, 15'h7FFF, 80'd0);       so[5] = 32'h7F800000;

    acc_n    = 0;
    out_n    = 0;
    stall_at = -1;
    for (int c = 0; c < 60 && out_n < 6; c++) begin
      o_ready = (c < 2 || c > 6);
      i_valid = (acc_n < 6);
      i       = (acc_n < 6) ? sv[acc_n] : '0;
      rm      = 3'd0;
      #1;
      if (i_valid && !i_ready && stall_at < 0) stall_at = acc_n;
      took_in  = i_valid & i_ready;
      took_out = o_valid & o_ready;
      got      = {o, o_flags};
      if (c >= 3 && c <= 6) check($sformatf("hold_c%0d", c), 64'(got), 64'({so[0], 5'd0}));
      @(posedge clk);
      #1;
      if (took_in) acc_n++;
      if (took_out) begin
        check($sformatf("stream_%0d", out_n), 64'(got), 64'({so[out_n], 5'd0}));
        out_n++;
      end
    end
    i_valid = 1'b0;
    check("stall_depth", 64'(stall_at), 64'd3);
    check("stream_count", 64'(out_n), 64'd6);

    o_ready = 1'b0;
    i_valid = 1'b1;
    i       = sv[1];
    @(posedge clk);
    #1;
    i       = sv[2];
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    check("pre_rst_ovalid", 64'(o_valid), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_ovalid", 64'(o_valid), 64'd0);
    check("mid_rst_iready", 64'(i_ready), 64'd0);
    check("mid_rst_o", 64'({o, o_flags}), 64'd0);
    rst_n   = 1'b1;
    o_ready = 1'b1;
    #1;
    check("post_rst_iready", 64'(i_ready), 64'd1);
    @(posedge clk);
    #1;
    check("post_rst_ovalid1", 64'(o_valid), 64'd0);
    @(posedge clk);
    #1;
    check("post_rst_ovalid2", 64'(o_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
